// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, phase type and hex segment table for the scan controller
package seg7_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF = 8'hFF;
    typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low {g..a} segment pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit 7-seg scanner with blanking and frame-coherent capture; SEG7_LZB_EN enables leading-zero blanking
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic        display_switch,
    input  logic [31:0] value_a,
    input  logic [31:0] value_b,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    logic [1:0]    sw_sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic          src_b_q, src_b_d;
    logic          frame_start, lzb_off, show;
    phase_t        ph;
    logic [3:0]    nib;
    logic [6:0]    hex_seg;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    seg7_hex_decode u_dec (.nib_i(nib), .seg_o(hex_seg));
    // next-state: counters, frame capture (forwarded so the first digit of a frame already uses it) and output decode
    always_comb begin
        frame_start = cnt_q == '0 && idx_q == '0;
        cnt_d = cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
        idx_d = cnt_q == CNT_MAX ? idx_q + 1'b1 : idx_q;
        snap_d = frame_start ? (sw_sync_q[1] ? value_b : value_a) : snap_q;
        src_b_d = frame_start ? sw_sync_q[1] : src_b_q;
        ph = cnt_q < BLANK_C ? PH_BLANK : PH_DRIVE;
        nib = snap_d[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        lzb_off = idx_q != '0 && (snap_d >> {idx_q, 2'b00}) == '0;
`else
        lzb_off = 1'b0;
`endif
        show = ph == PH_DRIVE && !lzb_off;
        an_d = show ? ~(8'd1 << idx_q) : AN_OFF;
        seg_d = show ? hex_seg : SEG_OFF;
        dp_d = !(ph == PH_DRIVE && idx_q == '0 && src_b_d);
    end
    // scan state, switch synchronizer and registered pin drivers
    always_ff @(posedge clk_100) begin
        if (reset) begin
            sw_sync_q <= 2'b00;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            src_b_q   <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            sw_sync_q <= {sw_sync_q[0], display_switch};
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            src_b_q   <= src_b_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end
    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized bench with a cycle-indexed behavioural model, two DUTs (BLANK=2 and BLANK=0)
module tb_seg7_scan_ctrl;
    localparam int DIV = 8;
    localparam int BL  = 2;
    logic        clk_100 = 1'b0;
    logic        reset = 1'b1;
    logic        display_switch = 1'b0;
    logic [31:0] value_a = '0;
    logic [31:0] value_b = '0;
    logic [6:0]  seg, seg0;
    logic        dp, dp0;
    logic [7:0]  an, an0;
    int checks = 0;
    int failures = 0;
    logic [6:0] hex_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    seg7_scan_ctrl #(.DIV(DIV), .BLANK(BL)) dut (
        .clk_100(clk_100), .reset(reset), .display_switch(display_switch),
        .value_a(value_a), .value_b(value_b), .seg(seg), .dp(dp), .an(an));
    seg7_scan_ctrl #(.DIV(DIV), .BLANK(0)) dut0 (
        .clk_100(clk_100), .reset(reset), .display_switch(display_switch),
        .value_a(value_a), .value_b(value_b), .seg(seg0), .dp(dp0), .an(an0));
    always #5 clk_100 = ~clk_100;
    // model state: cycles since reset release, switch history, frame value
    int          m_n = 0;
    logic        m_valid = 1'b0;
    logic        s1 = 1'b0, s2 = 1'b0;
    logic [31:0] fval = '0;
    logic        fsrc = 1'b0;
    logic [15:0] exp1 = '0, exp0 = '0;
    function automatic logic [15:0] model(int bl, int c, int k, logic [31:0] v, logic src);
        int nib;
        nib = int'((v >> (4 * k)) & 32'hF);
        if (c < bl) return {8'hFF, 7'h7F, 1'b1};
`ifdef SEG7_LZB_EN
        if (k > 0 && (v >> (4 * k)) == 0) return {8'hFF, 7'h7F, 1'b1};
`endif
        return {~(8'd1 << k), hex_t[nib], !(k == 0 && src)};
    endfunction
    always @(posedge clk_100) begin
        if (reset) begin
            m_n = 0; s1 = 0; s2 = 0; fval = '0; fsrc = 0; m_valid = 1;
            exp1 = {8'hFF, 7'h7F, 1'b1};
            exp0 = {8'hFF, 7'h7F, 1'b1};
        end else begin
            int c, k;
            logic sws;
            sws = s2; s2 = s1; s1 = display_switch;
            c = m_n % DIV;
            k = (m_n / DIV) % 8;
            if (c == 0 && k == 0) begin
                fval = sws ? value_b : value_a;
                fsrc = sws;
            end
            exp1 = model(BL, c, k, fval, fsrc);
            exp0 = model(0, c, k, fval, fsrc);
            m_n++;
        end
    end
    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask
    always @(negedge clk_100) begin
        if (m_valid) begin
            chk("dut_out", {an, seg, dp}, exp1);
            chk("dut0_out", {an0, seg0, dp0}, exp0);
            chk("an_onehot", {15'd0, $countones(~an) > 1}, 16'd0);
            chk("an0_onehot", {15'd0, $countones(~an0) > 1}, 16'd0);
`ifndef SEG7_LZB_EN
            if (m_n > DIV) chk("blank0_never_off", {15'd0, an0 == 8'hFF}, 16'd0);
`endif
        end
    end
    task automatic pin(string nm, logic [7:0] a_e, logic [6:0] s_e, logic d_e);
        chk(nm, {an, seg, dp}, {a_e, s_e, d_e});
    endtask
    task automatic step(int k);
        repeat (k) @(negedge clk_100);
    endtask
    task automatic restart();
        reset = 1'b1;
        @(negedge clk_100);
        reset = 1'b0;
        @(negedge clk_100);
    endtask
    function automatic logic [31:0] rv();
        return $urandom >> (4 * $urandom_range(0, 7));
    endfunction
    initial begin
        value_a = 32'h89ABCDEF;
        step(3);
        restart();
        pin("rst_n0_blank", 8'hFF, 7'h7F, 1'b1);
        chk("b0_n0_drive", {an0, seg0, dp0}, {8'hFE, 7'h0E, 1'b1});
        step(1);
        pin("n1_blank", 8'hFF, 7'h7F, 1'b1);
        step(1);
        pin("slot0_F", 8'hFE, 7'h0E, 1'b1);
        step(8);
        pin("slot1_E", 8'hFD, 7'h06, 1'b1);
        step(10);
        display_switch = 1'b1;
        value_b = 32'h00000001;
        value_a = 32'h12345678;
        step(38);
        pin("slot7_old_8", 8'h7F, 7'h00, 1'b1);
        step(8);
        pin("frame2_b_dig0", 8'hFE, 7'h79, 1'b0);
        step(8);
`ifdef SEG7_LZB_EN
        pin("frame2_b_dig1_lzb", 8'hFF, 7'h7F, 1'b1);
`else
        pin("frame2_b_dig1", 8'hFD, 7'h40, 1'b1);
`endif
        display_switch = 1'b0;
        restart();
        step(43);
        reset = 1'b1;
        @(negedge clk_100);
        pin("mid_reset_off", 8'hFF, 7'h7F, 1'b1);
        chk("mid_reset_off0", {an0, seg0, dp0}, {8'hFF, 7'h7F, 1'b1});
        reset = 1'b0;
        @(negedge clk_100);
        chk("post_reset_dig0", {an0, seg0, dp0}, {8'hFE, 7'h00, 1'b1});
        value_a = 32'h000000A5;
        restart();
        step(2);
        pin("a5_dig0", 8'hFE, 7'h12, 1'b1);
        step(8);
        pin("a5_dig1", 8'hFD, 7'h08, 1'b1);
        step(8);
`ifdef SEG7_LZB_EN
        pin("a5_dig2_lzb", 8'hFF, 7'h7F, 1'b1);
        value_a = 32'h0;
        restart();
        step(2);
        pin("zero_dig0", 8'hFE, 7'h40, 1'b1);
        step(8);
        pin("zero_dig1_lzb", 8'hFF, 7'h7F, 1'b1);
`else
        pin("a5_dig2", 8'hFB, 7'h40, 1'b1);
`endif
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_100);
            reset = $urandom_range(0, 599) == 0;
            if ($urandom_range(0, 149) == 0) display_switch = ~display_switch;
            if ($urandom_range(0, 9) == 0) value_a = rv();
            if ($urandom_range(0, 9) == 0) value_b = rv();
        end
        reset = 1'b0;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
